count_seq_checker: RTL and testbench

- Receive side of the free-running 8-bit counter stream produced by the per-clock counters.
- Samples a count value each valid cycle, locks onto an increment-by-one sequence, flywheels the expected value while locked, and reports sequence errors.
- Sits next to each counter instance in the same clock domain. CDC is out of scope: cnt_in and cnt_vld are synchronous to clk.

---
 rtl/count_seq_checker_if.sv | 25 ++
 rtl/count_seq_checker.sv | 119 +++++++++++
 tb/tb_count_seq_checker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_seq_checker_if.sv
// Handshake bundle between a counter stream source and its sequence checker.
// The master drives samples and clear; the slave returns lock and error status.
interface count_seq_checker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
);
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_vld;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       wrap_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output cnt_in, cnt_vld, clear,
        input  locked, err_pulse, err_count, wrap_count, expected
    );

    modport slave (
        input  cnt_in, cnt_vld, clear,
        output locked, err_pulse, err_count, wrap_count, expected
    );
endinterface

// File: rtl/count_seq_checker.sv
// Locks onto an increment-by-one count stream, flywheels the expected value
// while locked and counts mismatches and matched wraps.
module count_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input logic          clk,
    input logic          reset,
    count_seq_checker_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEARCH = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [WIDTH-1:0] MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLK_N  = 4'(UNLOCK_CNT);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       bad_q, bad_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       wrap_q, wrap_d;
    logic             pulse_q, pulse_d;
    logic             locked_q, locked_d;
    logic             match;

    assign match = (bus.cnt_in == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = err_q;
        wrap_d  = wrap_q;
        pulse_d = 1'b0;
        if (bus.cnt_vld) begin
            case (state_q)
                IDLE: begin
                    exp_d   = bus.cnt_in + 1'b1;
                    good_d  = '0;
                    state_d = SEARCH;
                end
                SEARCH: begin
                    exp_d = bus.cnt_in + 1'b1;
                    if (match) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: a bad sample never re-syncs until unlock
                    exp_d = exp_q + 1'b1;
                    if (match) begin
                        bad_d = '0;
                        if (exp_q == MAX)
                            wrap_d = wrap_q + 8'd1;
                    end else begin
                        pulse_d = 1'b1;
                        if (err_q != ERR_MAX)
                            err_d = err_q + 1'b1;
                        bad_d = bad_q + 4'd1;
                        if (bad_q + 4'd1 == UNLK_N) begin
                            state_d = SEARCH;
                            good_d  = '0;
                            exp_d   = bus.cnt_in + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (bus.clear) begin
            err_d  = '0;
            wrap_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            err_q    <= '0;
            wrap_q   <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = pulse_q;
    assign bus.err_count  = err_q;
    assign bus.wrap_count = wrap_q;
    assign bus.expected   = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: lock, wrap, flywheel, unlock,
// gaps, back-to-back errors, reset and error-counter saturation.
module tb_count_seq_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    count_seq_checker_if #(.WIDTH(8), .ERR_W(16)) m_if ();
    count_seq_checker_if #(.WIDTH(8), .ERR_W(16)) s_if ();

    count_seq_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    count_seq_checker #(.UNLOCK_CNT(15)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    task automatic send_m(input logic v, input logic [7:0] d,
                          input logic clr);
        m_if.cnt_vld = v;
        m_if.cnt_in  = d;
        m_if.clear   = clr;
        @(posedge clk);
        #1;
        m_if.cnt_vld = 1'b0;
        m_if.clear   = 1'b0;
    endtask

    task automatic send_s(input logic v, input logic [7:0] d,
                          input logic clr);
        s_if.cnt_vld = v;
        s_if.cnt_in  = d;
        s_if.clear   = clr;
        @(posedge clk);
        #1;
        s_if.cnt_vld = 1'b0;
        s_if.clear   = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (m_if.locked !== 1'b0 || m_if.err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00",
                     m_if.locked, m_if.err_pulse);
        end
        checks++;
        if (m_if.err_count !== 16'h0 || m_if.wrap_count !== 8'h0
            || m_if.expected !== 8'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h %h %h want 0 0 0",
                     m_if.err_count, m_if.wrap_count, m_if.expected);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lock;
        send_m(1'b1, 8'h10, 1'b0);
        checks++;
        if (m_if.expected !== 8'h11 || m_if.locked !== 1'b0) begin
            errors++;
            $display("FAIL first_sample got exp=%h lk=%b want 11 0",
                     m_if.expected, m_if.locked);
        end
        for (int i = 1; i < 4; i++) send_m(1'b1, 8'(8'h10 + i), 1'b0);
        checks++;
        if (m_if.locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got %b want 0", m_if.locked);
        end
        send_m(1'b1, 8'h14, 1'b0);
        checks++;
        if (m_if.locked !== 1'b1 || m_if.expected !== 8'h15
            || m_if.err_count !== 16'h0) begin
            errors++;
            $display("FAIL lock_rise got lk=%b exp=%h err=%h want 1 15 0",
                     m_if.locked, m_if.expected, m_if.err_count);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] tail [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 8'h15; i <= 8'hFC; i++) send_m(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            send_m(1'b1, tail[i], 1'b0);
            checks++;
            if (m_if.err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL wrap_pulse[%0d] got 1 want 0", i);
            end
        end
        checks++;
        if (m_if.wrap_count !== 8'd1 || m_if.expected !== 8'h02
            || m_if.locked !== 1'b1) begin
            errors++;
            $display("FAIL wrap got wc=%0d exp=%h lk=%b want 1 02 1",
                     m_if.wrap_count, m_if.expected, m_if.locked);
        end
    endtask

    task automatic test_flywheel;
        for (int i = 2; i < 8'h40; i++) send_m(1'b1, 8'(i), 1'b0);
        send_m(1'b1, 8'h99, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b1 || m_if.err_count !== 16'd1
            || m_if.locked !== 1'b1 || m_if.expected !== 8'h41) begin
            errors++;
            $display("FAIL fly_bad got p=%b e=%0d lk=%b x=%h want 1 1 1 41",
                     m_if.err_pulse, m_if.err_count, m_if.locked,
                     m_if.expected);
        end
        send_m(1'b1, 8'h41, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b0 || m_if.err_count !== 16'd1
            || m_if.locked !== 1'b1 || m_if.expected !== 8'h42) begin
            errors++;
            $display("FAIL fly_good got p=%b e=%0d lk=%b x=%h want 0 1 1 42",
                     m_if.err_pulse, m_if.err_count, m_if.locked,
                     m_if.expected);
        end
    endtask

    task automatic test_unlock;
        send_m(1'b0, 8'h00, 1'b1);
        checks++;
        if (m_if.err_count !== 16'd0 || m_if.wrap_count !== 8'd0
            || m_if.locked !== 1'b1 || m_if.expected !== 8'h42) begin
            errors++;
            $display("FAIL clear got e=%0d w=%0d lk=%b x=%h want 0 0 1 42",
                     m_if.err_count, m_if.wrap_count, m_if.locked,
                     m_if.expected);
        end
        send_m(1'b1, 8'h00, 1'b0);
        send_m(1'b1, 8'h05, 1'b0);
        checks++;
        if (m_if.locked !== 1'b1 || m_if.err_count !== 16'd2) begin
            errors++;
            $display("FAIL unlock_early got lk=%b e=%0d want 1 2",
                     m_if.locked, m_if.err_count);
        end
        send_m(1'b1, 8'h1F, 1'b0);
        checks++;
        if (m_if.locked !== 1'b0 || m_if.err_count !== 16'd3
            || m_if.expected !== 8'h20) begin
            errors++;
            $display("FAIL unlock got lk=%b e=%0d x=%h want 0 3 20",
                     m_if.locked, m_if.err_count, m_if.expected);
        end
        for (int i = 8'h20; i < 8'h23; i++) send_m(1'b1, 8'(i), 1'b0);
        checks++;
        if (m_if.locked !== 1'b0 || m_if.err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got lk=%b p=%b want 0 0",
                     m_if.locked, m_if.err_pulse);
        end
        send_m(1'b1, 8'h23, 1'b0);
        checks++;
        if (m_if.locked !== 1'b1 || m_if.err_count !== 16'd3
            || m_if.expected !== 8'h24) begin
            errors++;
            $display("FAIL relock got lk=%b e=%0d x=%h want 1 3 24",
                     m_if.locked, m_if.err_count, m_if.expected);
        end
    endtask

    task automatic test_gap;
        for (int i = 0; i < 5; i++) begin
            send_m(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            checks++;
            if (m_if.err_pulse !== 1'b0 || m_if.expected !== 8'h24) begin
                errors++;
                $display("FAIL gap[%0d] got p=%b x=%h want 0 24",
                         i, m_if.err_pulse, m_if.expected);
            end
        end
        send_m(1'b1, 8'h24, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b0 || m_if.locked !== 1'b1
            || m_if.expected !== 8'h25 || m_if.err_count !== 16'd3) begin
            errors++;
            $display("FAIL gap_resume got p=%b lk=%b x=%h e=%0d want 0 1 25 3",
                     m_if.err_pulse, m_if.locked, m_if.expected,
                     m_if.err_count);
        end
    endtask

    task automatic test_back_to_back;
        send_m(1'b1, 8'h77, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b1 || m_if.err_count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_first got p=%b e=%0d want 1 4",
                     m_if.err_pulse, m_if.err_count);
        end
        send_m(1'b1, 8'h78, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b1 || m_if.err_count !== 16'd5) begin
            errors++;
            $display("FAIL b2b_second got p=%b e=%0d want 1 5",
                     m_if.err_pulse, m_if.err_count);
        end
        send_m(1'b1, 8'h27, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b0 || m_if.locked !== 1'b1
            || m_if.expected !== 8'h28) begin
            errors++;
            $display("FAIL b2b_recover got p=%b lk=%b x=%h want 0 1 28",
                     m_if.err_pulse, m_if.locked, m_if.expected);
        end
    endtask

    task automatic test_reset_mid;
        m_if.cnt_vld = 1'b1;
        m_if.cnt_in  = 8'h55;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (m_if.locked !== 1'b0 || m_if.err_pulse !== 1'b0
            || m_if.err_count !== 16'd0 || m_if.wrap_count !== 8'd0
            || m_if.expected !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset got lk=%b p=%b e=%0d w=%0d x=%h want 0",
                     m_if.locked, m_if.err_pulse, m_if.err_count,
                     m_if.wrap_count, m_if.expected);
        end
        m_if.cnt_vld = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_m(1'b1, 8'h90, 1'b0);
        checks++;
        if (m_if.err_pulse !== 1'b0 || m_if.locked !== 1'b0
            || m_if.expected !== 8'h91 || m_if.err_count !== 16'd0) begin
            errors++;
            $display("FAIL post_reset got p=%b lk=%b x=%h e=%0d want 0 0 91 0",
                     m_if.err_pulse, m_if.locked, m_if.expected,
                     m_if.err_count);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] se;
        int run;
        for (int i = 0; i < 5; i++) send_s(1'b1, 8'(i), 1'b0);
        checks++;
        if (s_if.locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_lock got %b want 1", s_if.locked);
        end
        se  = 8'd5;
        run = 0;
        for (int n = 0; n < 65535; n++) begin
            send_s(1'b1, se ^ 8'h80, 1'b0);
            se++;
            run++;
            if (run == 14) begin
                send_s(1'b1, se, 1'b0);
                se++;
                run = 0;
            end
        end
        send_s(1'b1, se, 1'b0);
        se++;
        checks++;
        if (s_if.err_count !== 16'hFFFF || s_if.locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_reach got e=%h lk=%b want ffff 1",
                     s_if.err_count, s_if.locked);
        end
        send_s(1'b1, se ^ 8'h80, 1'b0);
        se++;
        checks++;
        if (s_if.err_count !== 16'hFFFF || s_if.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got e=%h p=%b want ffff 1",
                     s_if.err_count, s_if.err_pulse);
        end
        send_s(1'b1, se ^ 8'h80, 1'b1);
        checks++;
        if (s_if.err_count !== 16'h0 || s_if.err_pulse !== 1'b1
            || s_if.locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear got e=%h p=%b lk=%b want 0 1 1",
                     s_if.err_count, s_if.err_pulse, s_if.locked);
        end
    endtask

    initial begin
        m_if.cnt_vld = 1'b0;
        m_if.cnt_in  = '0;
        m_if.clear   = 1'b0;
        s_if.cnt_vld = 1'b0;
        s_if.cnt_in  = '0;
        s_if.clear   = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_flywheel();
        test_unlock();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
